// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: operation codes,
// FSM states and the step-size constants used by the step datapath.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] STEP1 = 3'd1;
    localparam logic [2:0] STEP2 = 3'd2;
    localparam logic [2:0] STEP4 = 3'd4;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle between the pipeline control (master) and the
// shift sequencer (slave).
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) ();
    import shift_ctrl_pkg::*;

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_data;

    modport master (
        output start, op, in_data, shamt,
        input  busy, done, out_data
    );

    modport slave (
        input  start, op, in_data, shamt,
        output busy, done, out_data
    );

endinterface

// File: rtl/shift_step_unit.sv
// Combinational fixed-distance shifter: moves a value by 1, 2 (or 4 when
// SHIFT_STEP4_EN is defined) bit positions according to the operation.
module shift_step_unit
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data,
    input  op_t              i_op,
    input  logic [2:0]       i_step,
    output logic [WIDTH-1:0] o_data
);

`ifdef SHIFT_STEP4_EN
    localparam int NLEG = 3;
`else
    localparam int NLEG = 2;
`endif

    // Leg gi shifts by 2**gi bits; the sequencer picks one leg per cycle.
    logic [WIDTH-1:0] w_leg [NLEG];

    genvar gi;
    generate
        for (gi = 0; gi < NLEG; gi++) begin : g_leg
            localparam int K = 1 << gi;
            assign w_leg[gi] =
                (i_op == OP_SLL) ? (i_data << K) :
                (i_op == OP_SRL) ? (i_data >> K) :
                (i_op == OP_SRA) ? WIDTH'($signed(i_data) >>> K) :
                                   {i_data[WIDTH-1-K:0], i_data[WIDTH-1:WIDTH-K]};
        end
    endgenerate

    always_comb begin
        o_data = w_leg[0];
        if (i_step == STEP2) o_data = w_leg[1];
`ifdef SHIFT_STEP4_EN
        if (i_step == STEP4) o_data = w_leg[2];
`endif
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: captures a request, applies greedy 2/1-bit
// steps (4/2/1 with SHIFT_STEP4_EN) until the amount is consumed, pulses done.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    shift_seq_ctrl_if.slave bus
);

    state_t           r_state;
    op_t              r_op;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_rem;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_step;
    logic [SHW-1:0]   w_rem_next;
    logic [WIDTH-1:0] w_stepped;

    // Largest available step that does not overshoot the remaining amount.
    always_comb begin
        w_step = STEP1;
        if (r_rem >= SHW'(2)) w_step = STEP2;
`ifdef SHIFT_STEP4_EN
        if (r_rem >= SHW'(4)) w_step = STEP4;
`endif
        w_rem_next = r_rem - SHW'(w_step);
    end

    shift_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data (r_work),
        .i_op   (r_op),
        .i_step (w_step),
        .o_data (w_stepped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_SLL;
            r_work  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op   <= bus.op;
                        r_work <= bus.in_data;
                        r_rem  <= bus.shamt;
                        r_busy <= 1'b1;
                        if (bus.shamt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_work <= w_stepped;
                    r_rem  <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result holds in the working register through DONE and IDLE.
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.out_data = r_work;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vectors, multi-cycle corner
// sequences and randomized requests against a plain-arithmetic shift model.
module tb_shift_seq_ctrl;
    import shift_ctrl_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    shift_seq_ctrl_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shift_seq_ctrl #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        op_t         op;
        logic [31:0] d;
        int          s;
        logic [31:0] exp;
        int          lat_off;
        int          lat_on;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input op_t op, input logic [31:0] d, input int s);
        logic [63:0] dd;
        case (op)
            OP_SLL:  return d << s;
            OP_SRL:  return d >> s;
            OP_SRA:  return 32'($signed(d) >>> s);
            default: begin
                dd = {d, d} << s;
                return dd[63:32];
            end
        endcase
    endfunction

    // Edges from acceptance to the edge that samples done (N steps + DONE).
    function automatic int ref_lat(input int s);
`ifdef SHIFT_STEP4_EN
        return (s / 4) + ((s >> 1) & 1) + (s & 1) + 1;
`else
        return ((s + 1) / 2) + 1;
`endif
    endfunction

    // Called one sample after the accepting edge; that sample is k=1.
    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = -1;
        res = '0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.done) begin
                lat = k;
                res = bus.out_data;
                check("busy_at_done", 64'(bus.busy), 64'd1);
                break;
            end
            check("busy_run", 64'(bus.busy), 64'd1);
            @(posedge clk); #1;
        end
        if (lat < 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic post_done_check(input logic [31:0] res);
        @(posedge clk); #1;
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("done_pulse", 64'(bus.done), 64'd0);
        check("hold_out", 64'(bus.out_data), 64'(res));
    endtask

    // Issue a request from IDLE; inputs are scrambled right after capture.
    task automatic run_req(input op_t op, input logic [31:0] d, input int s,
                           output int lat, output logic [31:0] res);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.in_data = d;
        bus.shamt   = SHW'(s);
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.op      = op_t'($urandom_range(0, 3));
        bus.in_data = $urandom;
        bus.shamt   = SHW'($urandom_range(0, 31));
        wait_done(lat, res);
        post_done_check(res);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat;
        int          exp_lat;
        int          s;
        op_t         op;
        logic [31:0] d;
        logic [31:0] res;
        logic [31:0] exp_res;

        n_asserts = 0;
        n_fail    = 0;

        vecs[0] = '{OP_SLL, 32'h0000_0001,  5, 32'h0000_0020,  4,  3};
        vecs[1] = '{OP_SRA, 32'h8000_0000, 31, 32'hFFFF_FFFF, 17, 10};
        vecs[2] = '{OP_SRL, 32'h8000_0000, 31, 32'h0000_0001, 17, 10};
        vecs[3] = '{OP_ROL, 32'h8000_0001,  1, 32'h0000_0003,  2,  2};
        vecs[4] = '{OP_ROL, 32'h8000_0001,  0, 32'h8000_0001,  1,  1};
        vecs[5] = '{OP_SLL, 32'hA5A5_A5A5,  8, 32'hA5A5_A500,  5,  3};
        vecs[6] = '{OP_ROL, 32'h1234_5678, 16, 32'h5678_1234,  9,  5};
        vecs[7] = '{OP_SRA, 32'h7FFF_0000,  4, 32'h07FF_F000,  3,  2};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = OP_SLL;
        bus.in_data = '0;
        bus.shamt   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_out", 64'(bus.out_data), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
`ifdef SHIFT_STEP4_EN
            exp_lat = vecs[i].lat_on;
`else
            exp_lat = vecs[i].lat_off;
`endif
            run_req(vecs[i].op, vecs[i].d, vecs[i].s, lat, res);
            $display("vec %0d op=%0d d=0x%08h s=%0d -> 0x%08h lat=%0d", i,
                     vecs[i].op, vecs[i].d, vecs[i].s, res, lat);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
        end

        // start held high through a whole request: only the first is taken,
        // and the still-high start is accepted on the first IDLE cycle.
        bus.start   = 1'b1;
        bus.op      = OP_SLL;
        bus.in_data = 32'h0000_0001;
        bus.shamt   = 5'd8;
        @(posedge clk); #1;
        bus.in_data = 32'hFFFF_FFFF;
        bus.shamt   = 5'd3;
        wait_done(lat, res);
        $display("hold_start first d=0x00000001 s=8 -> 0x%08h lat=%0d", res, lat);
        check("hold_first_result", 64'(res), 64'h100);
        check("hold_first_latency", 64'(lat), 64'(ref_lat(8)));
        @(posedge clk); #1;
        check("hold_idle_busy", 64'(bus.busy), 64'd0);
        check("hold_single_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        check("hold_second_accept", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(lat, res);
        $display("hold_start second d=0xffffffff s=3 -> 0x%08h lat=%0d", res, lat);
        check("hold_second_result", 64'(res), 64'hFFFF_FFF8);
        check("hold_second_latency", 64'(lat), 64'(ref_lat(3)));
        post_done_check(res);

        // Reset on the second RUN cycle aborts without a done pulse.
        bus.start   = 1'b1;
        bus.op      = OP_SLL;
        bus.in_data = 32'h0000_00FF;
        bus.shamt   = 5'd20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("abort s=20 by reset in second RUN cycle");
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_out", 64'(bus.out_data), 64'd0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", 64'(bus.done), 64'd0);
        end
        run_req(OP_SRL, 32'hF000_0000, 20, lat, res);
        $display("after_abort op=1 d=0xf0000000 s=20 -> 0x%08h lat=%0d", res, lat);
        check("after_abort_result", 64'(res), 64'h0000_0F00);
        check("after_abort_latency", 64'(lat), 64'(ref_lat(20)));

        // Reset and start together: the request is dropped.
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.in_data = 32'h1234_5678;
        bus.shamt   = 5'd0;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        $display("reset_with_start dropped");
        check("rst_start_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        check("rst_start_no_done", 64'(bus.done), 64'd0);
        check("rst_start_out", 64'(bus.out_data), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            op = op_t'($urandom_range(0, 3));
            d  = $urandom;
            s  = $urandom_range(0, 31);
            exp_res = ref_shift(op, d, s);
            exp_lat = ref_lat(s);
            run_req(op, d, s, lat, res);
            $display("rnd %0d op=%0d d=0x%08h s=%0d -> 0x%08h lat=%0d", i, op, d, s, res, lat);
            check("rnd_result", 64'(res), 64'(exp_res));
            check("rnd_latency", 64'(lat), 64'(exp_lat));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle shift sequencer for the KGP-RISC execute stage. It accepts a shift request (operand, amount, type), holds it in internal registers, and steps a small fixed-distance shift datapath (1- or 2-bit per cycle) until the requested amount is consumed. It then presents the result with a one-cycle `done` pulse. It replaces a full 32-bit barrel shifter on the `shll/shrl/shra`-family instructions, and the pipeline control stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result width (power of two, ≥ 8)
- `SHW`, 5, shift-amount width (= log2(WIDTH))
- `clk`  input  1  single system clock, all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  request strobe; sampled only in IDLE
- `op`  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
- `in_data`  input  WIDTH  operand, captured with `start`
- `shamt`  input  SHW  shift amount, captured with `start`
- `busy`  output  1  high from cycle after accepted `start` until `done` cycle inclusive
- `done`  output  1  one-cycle pulse, result valid
- `out_data`  output  WIDTH  result; held stable from `done` until next accepted `start`

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: on `start`=1, capture `op`, `in_data` into the working register, and `shamt` into `rem`. Go to DONE if `shamt`=0, else to RUN.
  - RUN: each cycle apply one step. Step size: 4 if macro enabled and `rem`≥4, else 2 if `rem`≥2, else 1. Set `rem` ← `rem` − step. Go to DONE when the new `rem`=0.
  - DONE: `done`=1 and `busy`=1; unconditionally go to IDLE next cycle.
- Step semantics, per step of k bits:
  - SLL: zero-fill low k bits.
  - SRL: zero-fill high k bits.
  - SRA: fill high k bits with the bit[WIDTH-1] of the current working value.
  - ROL: bits shifted out at the MSB re-enter at the LSB.
- `out_data` is driven from the working register. Intermediate values are visible during RUN but only meaningful at `done`.
- `start` in RUN or DONE is ignored (no queueing). Requester must wait for IDLE (`busy`=0).
- Input changes on `op`/`in_data`/`shamt` after capture have no effect.
- Reset values: state IDLE, `busy`=0, `done`=0, `out_data`=0, `rem`=0.
- `rst` mid-operation aborts on that edge: IDLE, outputs at reset values, no `done` issued.
- `rst` and `start` in the same cycle: reset wins, request dropped.

## Timing
- Request accepted at edge E0 (IDLE, `start`=1).
- Number of steps N = number of RUN cycles (greedy 2/1 decomposition without macro):
  - `shamt`=0 → N=0.
  - Otherwise N = ceil(`shamt`/2).
- `done` is asserted in cycle E0+N+1. Worst case is `shamt`=31: N=16, `done` at E0+17.
- Back-to-back: the next `start` can be accepted at E0+N+2, the first IDLE cycle. Peak throughput is one request per N+2 cycles.
- `busy` drops in the same cycle the FSM re-enters IDLE.

## Configuration
- `SHIFT_STEP4_EN` defined:
  - Adds a 4-bit step.
  - Greedy decomposition is 4/2/1; N = floor(`shamt`/4) + popcount(`shamt`[1:0]).
  - Example: `shamt`=31 → N=9, `done` at E0+10.
- Not defined:
  - Step set {2,1} only; no 4-bit path in RTL.
  - N = ceil(`shamt`/2).
- Functional results are identical either way; only latency differs.

## Structure
- Package `shift_ctrl_pkg`:
  - Op encodings `OP_SLL/OP_SRL/OP_SRA/OP_ROL`.
  - FSM state enum.
  - Step constants `STEP1/STEP2/STEP4`.
- Sub-module `shift_step_unit`: purely combinational, shifts a WIDTH-bit value by a selected step (1/2/4) under `op`.
  - 4-bit leg present only under `SHIFT_STEP4_EN`.
  - Instantiated once; all sequencing stays in `shift_seq_ctrl`.

## Test plan
- SLL, `in_data`=0x0000_0001, `shamt`=5, macro off → 3 RUN cycles, `done` at E0+4, `out_data`=0x0000_0020; with macro → 2 RUN cycles, `done` at E0+3.
- SRA, `in_data`=0x8000_0000, `shamt`=31 → `out_data`=0xFFFF_FFFF, `done` at E0+17 (off) / E0+10 (on); same input with SRL → 0x0000_0001.
- ROL, `in_data`=0x8000_0001, `shamt`=1 → `out_data`=0x0000_0003, `done` at E0+2; `shamt`=0 → `out_data`=0x8000_0001, `done` at E0+1.
- `start` re-asserted every cycle during a `shamt`=8 SLL → only the first request is executed, one `done` pulse; the next `start` is accepted on the first IDLE cycle.
- `rst` asserted on the second RUN cycle of a `shamt`=20 request → next cycle `busy`=0, `out_data`=0, no `done`; a new request then completes normally.
- Random op/`in_data`/`shamt` (≥1000 requests, both macro settings) → `out_data` matches the reference shift/rotate, and `done` latency matches N+1.
